// File: rtl/ee354_project_tick_ctrl_if.sv
// ---------------------------------------------------------------------------
// ee354_project_tick_ctrl_if
// Handshake bundle between the tick controller and its neighbours.
//   master : debouncers / state machine / length / apple side
//   slave  : the tick controller itself
// Inputs to the controller:
//   q_Run       state machine is in Run
//   Dir_Valid   one-cycle direction press strobe
//   Dir_In      direction of the press (00 up, 01 down, 10 left, 11 right)
//   Length      current snake length
//   Move_Done   length module finished the move/collision update
//   New_Apple   apple eaten on this move
//   Apple_Done  apple generator placed the new apple
// Outputs from the controller:
//   Move_Req    one-cycle move request
//   Move_Dirn   direction for the move
//   Apple_Req   one-cycle apple regeneration request
//   Tick_Busy   controller is not idle
//   Q_Count     queued directions (0..2)
//   Drop        one-cycle pulse when a press is rejected
// ---------------------------------------------------------------------------
interface ee354_project_tick_ctrl_if;
    localparam int unsigned DIR_W  = 2;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned QCNT_W = 2;

    logic              q_Run;
    logic              Dir_Valid;
    logic [DIR_W-1:0]  Dir_In;
    logic [LEN_W-1:0]  Length;
    logic              Move_Done;
    logic              New_Apple;
    logic              Apple_Done;

    logic              Move_Req;
    logic [DIR_W-1:0]  Move_Dirn;
    logic              Apple_Req;
    logic              Tick_Busy;
    logic [QCNT_W-1:0] Q_Count;
    logic              Drop;

    modport master (
        output q_Run, Dir_Valid, Dir_In, Length, Move_Done, New_Apple, Apple_Done,
        input  Move_Req, Move_Dirn, Apple_Req, Tick_Busy, Q_Count, Drop
    );

    modport slave (
        input  q_Run, Dir_Valid, Dir_In, Length, Move_Done, New_Apple, Apple_Done,
        output Move_Req, Move_Dirn, Apple_Req, Tick_Busy, Q_Count, Drop
    );
endinterface

// File: rtl/ee354_project_tick_ctrl.sv
// ---------------------------------------------------------------------------
// ee354_project_tick_ctrl
// Move scheduler for the snake datapath. Generates a game tick whose period
// shrinks as the snake grows, buffers direction presses in a 2-entry queue
// that rejects repeats/reversals, and sequences one move (length module)
// followed by an optional apple regeneration (apple generator) per tick.
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high reset
//   bus    ee354_project_tick_ctrl_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module ee354_project_tick_ctrl #(
    parameter int unsigned TICK_BASE = 25000000,
    parameter int unsigned TICK_STEP = 500000,
    parameter int unsigned TICK_MIN  = 5000000,   // must not exceed TICK_BASE
    parameter logic [1:0]  INIT_DIRN = 2'b11
) (
    input  logic                      Clk,
    input  logic                      Reset,
    ee354_project_tick_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DIR_W  = 2;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned QCNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2,
        APPLE = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                run_q;
    logic [DIR_W-1:0]    cur_dirn_q;
    logic [DIR_W-1:0]    q0_q;          // queue head
    logic [DIR_W-1:0]    q1_q;
    logic [QCNT_W-1:0]   qcnt_q;
    logic                move_req_q;
    logic [DIR_W-1:0]    move_dirn_q;
    logic                apple_req_q;
    logic                tick_busy_q;
    logic                drop_q;

    // Tick period from snake length, clamped to the floor before subtracting.
    logic [LEN_W-1:0]    len_excess;
    logic [CNT_W-1:0]    step_red;
    logic [CNT_W-1:0]    period;

    always_comb begin
        len_excess = '0;
        step_red   = '0;
        period     = CNT_W'(TICK_BASE);
        if (bus.Length > LEN_W'(3)) begin
            len_excess = bus.Length - LEN_W'(3);
        end
        step_red = CNT_W'(len_excess) * CNT_W'(TICK_STEP);
        if (step_red >= CNT_W'(TICK_BASE - TICK_MIN)) begin
            period = CNT_W'(TICK_MIN);
        end else begin
            period = CNT_W'(TICK_BASE) - step_red;
        end
    end

    // Counter value seen this cycle: a q_Run rising cycle acts as a load of
    // the period plus its first decrement, so Move_Req lands P cycles later.
    logic                run_rise;
    logic [CNT_W-1:0]    cnt_cur;

    always_comb begin
        run_rise = bus.q_Run && !run_q;
        cnt_cur  = run_rise ? period : cnt_q;
    end

    // Direction queue: pop (on the Move_Req cycle) is applied before the push,
    // and the push is judged against the post-pop tail / current direction.
    logic                pop_now;
    logic                push_now;
    logic                push_rej;
    logic                push_ok;
    logic [DIR_W-1:0]    cur_pop;
    logic [DIR_W-1:0]    q0_pop;
    logic [DIR_W-1:0]    q1_pop;
    logic [QCNT_W-1:0]   qcnt_pop;
    logic [DIR_W-1:0]    ref_dirn;
    logic [DIR_W-1:0]    q0_d;
    logic [DIR_W-1:0]    q1_d;
    logic [QCNT_W-1:0]   qcnt_d;
    logic [DIR_W-1:0]    cur_dirn_d;
    logic [DIR_W-1:0]    peek_dirn;

    always_comb begin
        pop_now  = (state_q == MOVE) && move_req_q;
        cur_pop  = cur_dirn_q;
        q0_pop   = q0_q;
        q1_pop   = q1_q;
        qcnt_pop = qcnt_q;
        if (pop_now && (qcnt_q != QCNT_W'(0))) begin
            cur_pop  = q0_q;
            q0_pop   = q1_q;
            qcnt_pop = qcnt_q - QCNT_W'(1);
        end

        case (qcnt_pop)
            QCNT_W'(0): ref_dirn = cur_pop;
            QCNT_W'(1): ref_dirn = q0_pop;
            default:    ref_dirn = q1_pop;
        endcase

        // Matching the axis bit of the reference covers repeat and reversal.
        push_now = bus.Dir_Valid && bus.q_Run;
        push_rej = push_now &&
                   ((bus.Dir_In[1] == ref_dirn[1]) || (qcnt_pop == QCNT_W'(2)));
        push_ok  = push_now && !push_rej;

        q0_d       = q0_pop;
        q1_d       = q1_pop;
        qcnt_d     = qcnt_pop;
        cur_dirn_d = cur_pop;
        if (push_ok) begin
            if (qcnt_pop == QCNT_W'(0)) begin
                q0_d = bus.Dir_In;
            end else begin
                q1_d = bus.Dir_In;
            end
            qcnt_d = qcnt_pop + QCNT_W'(1);
        end

        // Direction the upcoming pop will produce; loaded into Move_Dirn with
        // Move_Req so the move direction is valid from the request onward.
        peek_dirn = (qcnt_d != QCNT_W'(0)) ? q0_d : cur_dirn_d;
    end

    // Tick/move/apple sequencer with registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            cur_dirn_q  <= INIT_DIRN;
            q0_q        <= '0;
            q1_q        <= '0;
            qcnt_q      <= '0;
            move_req_q  <= 1'b0;
            move_dirn_q <= INIT_DIRN;
            apple_req_q <= 1'b0;
            tick_busy_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            run_q       <= bus.q_Run;
            move_req_q  <= 1'b0;
            apple_req_q <= 1'b0;
            drop_q      <= push_rej;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            qcnt_q      <= qcnt_d;
            cur_dirn_q  <= cur_dirn_d;

            if (!bus.q_Run) begin
                // Leaving Run: abandon the tick, flush presses, hold the counter.
                state_q     <= IDLE;
                tick_busy_q <= 1'b0;
                qcnt_q      <= '0;
                cur_dirn_q  <= INIT_DIRN;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cnt_cur <= CNT_W'(1)) begin
                            state_q     <= MOVE;
                            cnt_q       <= '0;
                            move_req_q  <= 1'b1;
                            tick_busy_q <= 1'b1;
                            move_dirn_q <= peek_dirn;
                        end else begin
                            cnt_q <= cnt_cur - CNT_W'(1);
                        end
                    end
                    MOVE: begin
                        if (pop_now) begin
                            move_dirn_q <= cur_dirn_d;
                        end
                        if (bus.Move_Done) begin
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (bus.New_Apple) begin
                            state_q     <= APPLE;
                            apple_req_q <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                            tick_busy_q <= 1'b0;
                            cnt_q       <= period;
                        end
                    end
                    APPLE: begin
                        if (bus.Apple_Done) begin
                            state_q     <= IDLE;
                            tick_busy_q <= 1'b0;
                            cnt_q       <= period;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        tick_busy_q <= 1'b0;
                        cnt_q       <= period;
                    end
                endcase
            end
        end
    end

    assign bus.Move_Req  = move_req_q;
    assign bus.Move_Dirn = move_dirn_q;
    assign bus.Apple_Req = apple_req_q;
    assign bus.Tick_Busy = tick_busy_q;
    assign bus.Q_Count   = qcnt_q;
    assign bus.Drop      = drop_q;
endmodule

// File: tb/tb_ee354_project_tick_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ee354_project_tick_ctrl
// Directed bench for the tick controller (TICK_BASE=20, TICK_STEP=2,
// TICK_MIN=6). Expected move spacing and direction are queued as the
// stimulus is applied and compared as each Move_Req appears.
// ---------------------------------------------------------------------------
module tb_ee354_project_tick_ctrl;
    logic Clk = 1'b0;
    logic Reset;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ref_cyc = 0;

    typedef struct {
        int         gap;
        logic [1:0] dirn;
    } exp_t;
    exp_t sb_q[$];

    ee354_project_tick_ctrl_if bus();

    ee354_project_tick_ctrl #(
        .TICK_BASE(20),
        .TICK_STEP(2),
        .TICK_MIN (6),
        .INIT_DIRN(2'b11)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic expect_move(input int gap, input logic [1:0] dirn);
        exp_t e;
        e.gap  = gap;
        e.dirn = dirn;
        sb_q.push_back(e);
    endtask

    task automatic press(input logic [1:0] d);
        bus.Dir_Valid = 1'b1;
        bus.Dir_In    = d;
        @(negedge Clk);
        bus.Dir_Valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_move_req"},  32'(bus.Move_Req),  32'd0);
        check({tag, "_apple_req"}, 32'(bus.Apple_Req), 32'd0);
        check({tag, "_drop"},      32'(bus.Drop),      32'd0);
        check({tag, "_busy"},      32'(bus.Tick_Busy), 32'd0);
        check({tag, "_qcount"},    32'(bus.Q_Count),   32'd0);
        check({tag, "_dirn"},      32'(bus.Move_Dirn), 32'd3);
    endtask

    // Wait for the next Move_Req, score it, then answer it.
    task automatic do_move(input logic [7:0] next_len, input bit press_on_req,
                           input logic [1:0] press_dir, input int exp_qcnt,
                           input bit serve, input bit apple, input int apple_dly,
                           input bit rst_in_apple);
        int   waited;
        int   extra;
        int   busy_bad;
        exp_t e;
        waited = 0;
        do begin
            @(negedge Clk);
            waited++;
        end while (bus.Move_Req !== 1'b1 && waited < 200);
        check("move_seen", 32'(bus.Move_Req), 32'd1);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check("move_gap",  32'(cyc - ref_cyc),  32'(e.gap));
        check("move_dirn", 32'(bus.Move_Dirn),  32'(e.dirn));
        check("busy_move", 32'(bus.Tick_Busy),  32'd1);
        ref_cyc    = cyc;
        bus.Length = next_len;
        if (press_on_req) begin
            bus.Dir_Valid = 1'b1;
            bus.Dir_In    = press_dir;
        end
        @(negedge Clk);
        bus.Dir_Valid = 1'b0;
        check("req_pulse", 32'(bus.Move_Req), 32'd0);
        if (press_on_req) begin
            check("req_push_drop", 32'(bus.Drop),    32'd0);
            check("req_push_qcnt", 32'(bus.Q_Count), 32'(exp_qcnt));
        end
        if (!serve) return;
        @(negedge Clk);
        bus.Move_Done = 1'b1;
        @(negedge Clk);
        bus.Move_Done = 1'b0;
        check("dirn_stable", 32'(bus.Move_Dirn), 32'(e.dirn));
        bus.New_Apple = apple;
        @(negedge Clk);
        bus.New_Apple = 1'b0;
        if (!apple) begin
            check("busy_idle", 32'(bus.Tick_Busy), 32'd0);
            return;
        end
        check("apple_req",  32'(bus.Apple_Req), 32'd1);
        check("busy_apple", 32'(bus.Tick_Busy), 32'd1);
        if (rst_in_apple) begin
            @(negedge Clk);
            Reset = 1'b1;
            @(negedge Clk);
            check_reset_vals("rst_apple");
            Reset = 1'b0;
            return;
        end
        extra    = 0;
        busy_bad = 0;
        repeat (apple_dly) begin
            @(negedge Clk);
            if (bus.Apple_Req === 1'b1) extra++;
            if (bus.Tick_Busy !== 1'b1) busy_bad++;
        end
        check("apple_single", 32'(extra),    32'd0);
        check("apple_busy",   32'(busy_bad), 32'd0);
        bus.Apple_Done = 1'b1;
        @(negedge Clk);
        bus.Apple_Done = 1'b0;
        check("busy_after_apple", 32'(bus.Tick_Busy), 32'd0);
    endtask

    initial begin
        int extra;
        Reset          = 1'b1;
        bus.q_Run      = 1'b0;
        bus.Dir_Valid  = 1'b0;
        bus.Dir_In     = 2'b00;
        bus.Length     = 8'd3;
        bus.Move_Done  = 1'b0;
        bus.New_Apple  = 1'b0;
        bus.Apple_Done = 1'b0;
        repeat (3) @(negedge Clk);
        check_reset_vals("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Base period, then period vs. length (8 -> 10, 20 -> floor 6, 0 -> 20).
        bus.q_Run = 1'b1;
        ref_cyc   = cyc;
        expect_move(20, 2'b11);
        do_move(8'd3, 1'b0, 2'b00, 0, 1'b1, 1'b0, 0, 1'b0);
        expect_move(24, 2'b11);
        do_move(8'd8, 1'b0, 2'b00, 0, 1'b1, 1'b0, 0, 1'b0);
        expect_move(14, 2'b11);
        do_move(8'd20, 1'b0, 2'b00, 0, 1'b1, 1'b0, 0, 1'b0);
        expect_move(10, 2'b11);
        do_move(8'd0, 1'b0, 2'b00, 0, 1'b1, 1'b0, 0, 1'b0);
        expect_move(24, 2'b11);
        do_move(8'd3, 1'b0, 2'b00, 0, 1'b1, 1'b0, 0, 1'b0);

        // Reversal rejected, two valid presses queued, full queue rejects.
        press(2'b10);
        check("rev_drop", 32'(bus.Drop),    32'd1);
        check("rev_qcnt", 32'(bus.Q_Count), 32'd0);
        @(negedge Clk);
        check("drop_pulse", 32'(bus.Drop), 32'd0);
        press(2'b00);
        check("push1_qcnt", 32'(bus.Q_Count), 32'd1);
        check("push1_drop", 32'(bus.Drop),    32'd0);
        press(2'b10);
        check("push2_qcnt", 32'(bus.Q_Count), 32'd2);
        press(2'b01);
        check("full_drop", 32'(bus.Drop),    32'd1);
        check("full_qcnt", 32'(bus.Q_Count), 32'd2);

        // Press into a full queue on the pop cycle is accepted.
        expect_move(24, 2'b00);
        do_move(8'd3, 1'b1, 2'b01, 2, 1'b1, 1'b0, 0, 1'b0);
        expect_move(24, 2'b10);
        do_move(8'd3, 1'b0, 2'b00, 0, 1'b1, 1'b0, 0, 1'b0);
        check("qcnt_after_m7", 32'(bus.Q_Count), 32'd1);

        // Apple round with Apple_Done held off 5 cycles.
        expect_move(24, 2'b01);
        do_move(8'd3, 1'b0, 2'b00, 0, 1'b1, 1'b1, 5, 1'b0);
        check("qcnt_empty", 32'(bus.Q_Count), 32'd0);

        // Fill the queue, then drop q_Run while in MOVE.
        press(2'b10);
        press(2'b00);
        check("refill_qcnt", 32'(bus.Q_Count), 32'd2);
        expect_move(30, 2'b10);
        do_move(8'd3, 1'b1, 2'b11, 2, 1'b0, 1'b0, 0, 1'b0);
        bus.q_Run = 1'b0;
        @(negedge Clk);
        check("stop_busy", 32'(bus.Tick_Busy), 32'd0);
        check("stop_qcnt", 32'(bus.Q_Count),   32'd0);
        press(2'b11);
        check("stop_press_drop", 32'(bus.Drop),    32'd0);
        check("stop_press_qcnt", 32'(bus.Q_Count), 32'd0);
        extra = 0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Move_Req === 1'b1) extra++;
        end
        check("stop_no_req", 32'(extra), 32'd0);

        // Restart from the initial direction, then reset while in APPLE.
        bus.q_Run     = 1'b1;
        ref_cyc       = cyc;
        bus.Dir_Valid = 1'b1;
        bus.Dir_In    = 2'b00;
        @(negedge Clk);
        bus.Dir_Valid = 1'b0;
        check("restart_qcnt", 32'(bus.Q_Count), 32'd1);
        check("restart_drop", 32'(bus.Drop),    32'd0);
        expect_move(20, 2'b00);
        do_move(8'd3, 1'b1, 2'b10, 1, 1'b1, 1'b1, 0, 1'b1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ee354_project_tick_ctrl.md
Name: ee354_project_tick_ctrl

Overview:
Move scheduler for the snake datapath. It generates the game tick, which speeds up as the snake grows. It buffers debounced direction presses in a 2-entry queue that rejects reversals. Each tick it sequences one move/collision update in the length module, then an optional apple regeneration in the apple generator. It sits between the debouncers/state machine and the length and apple modules, and replaces the free-running Speed_Clk.

Parameters:
TICK_BASE, 25000000, tick period in Clk cycles at Length <= 3 (250 ms at 100 MHz)
TICK_STEP, 500000, period reduction per unit of Length above 3
TICK_MIN, 5000000, minimum tick period (saturation floor)
INIT_DIRN, 2'b11, direction after reset or restart (00 up, 01 down, 10 left, 11 right)

Ports:
Clk  in  1  system clock (100 MHz)
Reset  in  1  synchronous, active-high reset
q_Run  in  1  state machine is in Run
Dir_Valid  in  1  single-cycle pulse: a direction button was pressed
Dir_In  in  2  direction of the press, valid with Dir_Valid
Length  in  8  current snake length
Move_Done  in  1  length module has finished the move and collision update
New_Apple  in  1  apple eaten on this move; sampled in CHECK
Apple_Done  in  1  apple generator has placed the new apple
Move_Req  out  1  single-cycle pulse: perform one move
Move_Dirn  out  2  direction for the move; stable from Move_Req until Move_Done
Apple_Req  out  1  single-cycle pulse: generate a new apple
Tick_Busy  out  1  high in every state except IDLE
Q_Count  out  2  number of queued directions (0..2)
Drop  out  1  single-cycle pulse: a press was rejected

Behaviour:
- Reset values: Move_Req=0, Apple_Req=0, Drop=0, Tick_Busy=0, Q_Count=0, Move_Dirn=INIT_DIRN, Cur_Dirn=INIT_DIRN, FSM=IDLE, counter=0. Reset has priority over all other events in every state.
- Period P = max(TICK_MIN, TICK_BASE - (max(Length,3)-3)*TICK_STEP).
  - Compute in 32 bits; clamp before any subtraction can underflow.
  - Sample P only when the counter loads.
- FSM states: IDLE, MOVE, CHECK, APPLE.
  - IDLE: the counter loads P on entry to IDLE and on the q_Run rising edge. It decrements once per cycle while q_Run=1. In the cycle it decrements 1 -> 0, the next state is MOVE. Move_Req therefore fires exactly P cycles after IDLE entry.
  - MOVE: Move_Req=1 on the first MOVE cycle only. The queue pops on that same cycle (see below). Stay in MOVE until Move_Done=1, then go to CHECK. Move_Done on the Move_Req cycle is accepted.
  - CHECK: one cycle. If New_Apple=1, go to APPLE; otherwise go to IDLE.
  - APPLE: Apple_Req=1 on the first APPLE cycle only. Stay until Apple_Done=1, then go to IDLE.
  - The counter is frozen outside IDLE.
- q_Run=0 from any state: next cycle is IDLE, queue is flushed (Q_Count=0), Cur_Dirn=INIT_DIRN, counter is held. No request pulses are issued while q_Run=0.
- Direction queue (2-entry FIFO; head is popped first):
  - Reference direction ref = tail entry if Q_Count>0, else Cur_Dirn.
  - A press is rejected when Dir_In[1]==ref[1], which covers both a repeat and a reversal.
  - A press is also rejected when the queue is full with no pop on the same cycle.
  - A press is ignored entirely (no Drop) when q_Run=0.
  - Every rejection produces a one-cycle Drop pulse, aligned to the cycle after Dir_Valid.
  - On the Move_Req cycle: if Q_Count>0, pop the head and Cur_Dirn <= head; otherwise Cur_Dirn is unchanged. Move_Dirn <= the resulting Cur_Dirn on the same edge.
- Simultaneous push and pop: the pop is applied first. The push is then checked against the post-pop reference. A push into a full queue that pops on the same cycle is accepted, and Q_Count stays 2.

Test Plan:
All scenarios use TICK_BASE=20, TICK_STEP=2, TICK_MIN=6.
1. Reset, then q_Run=1, Length=3, no presses, Move_Done returned 2 cycles after each Move_Req, New_Apple=0 -> first Move_Req 20 cycles after q_Run rises; later Move_Reqs every 24 cycles; Move_Dirn=11.
2. Length=8 -> period 10; Length=20 -> period 6 (floor); Length=0 -> period 20.
3. Cur_Dirn=11, press 10 -> Drop pulse, Q_Count=0. Then press 00 and 10 -> Q_Count=2; the next two Move_Reqs carry Move_Dirn 00 then 10.
4. Queue holds {00,10}, press 01 -> Drop, Q_Count stays 2. Press 01 again on a Move_Req cycle -> accepted, Q_Count=2, queue holds {10,01}.
5. New_Apple=1 in CHECK, Apple_Done held off for 5 cycles -> exactly one Apple_Req pulse, Tick_Busy=1 throughout, counter frozen; IDLE and a reload of P follow Apple_Done.
6. q_Run dropped in MOVE with Q_Count=2 -> IDLE next cycle, Q_Count=0, no further Move_Req. Reset asserted in APPLE -> all outputs at their reset values on the next cycle.
